// File: rtl/msx_mouse_pkg.sv
// msx_mouse_pkg: shared types, constants and helpers for the MSX mouse port.
//   nib_state_t : nibble sequencer state (NIB0..NIB3)
//   PORT_RESET  : joystick port idle value (all lines released)
//   SAT_MAX/MIN : 8-bit signed saturation bounds
//   nib_rev     : bit-reversed high or low nibble of a byte
//   sat8        : saturate a 10-bit signed value into 8 bits
package msx_mouse_pkg;

  typedef enum logic [1:0] {
    NIB0 = 2'd0,  // X[7:4]
    NIB1 = 2'd1,  // X[3:0]
    NIB2 = 2'd2,  // Y[7:4]
    NIB3 = 2'd3   // Y[3:0]
  } nib_state_t;

  localparam logic [5:0]        PORT_RESET = 6'h3F;
  localparam logic signed [9:0] SAT_MAX    = 10'sd127;
  localparam logic signed [9:0] SAT_MIN    = -10'sd128;

  // The MSX side expects the nibble MSB on bit0, so the lines are reversed.
  function automatic logic [3:0] nib_rev(input logic [7:0] b, input logic hi);
    logic [3:0] n;
    n = hi ? b[7:4] : b[3:0];
    return {n[0], n[1], n[2], n[3]};
  endfunction

  function automatic logic [7:0] sat8(input logic signed [9:0] v);
    logic [7:0] r;
    if (v > SAT_MAX)      r = 8'h7F;
    else if (v < SAT_MIN) r = 8'h80;
    else                  r = v[7:0];
    return r;
  endfunction

endpackage

// File: rtl/mouse_delta_acc.sv
// mouse_delta_acc: one saturating 8-bit movement accumulator (one per axis).
//   clk, srst : clock, synchronous active-high reset
//   add_en    : take a new 9-bit delta this cycle
//   delta     : signed 9-bit PS/2 delta
//   neg       : negate the delta before adding (Y axis)
//   clr       : clear the accumulator (applied before any add in the same cycle)
//   acc       : current accumulator value
// Macro MSX_MOUSE_ACCUM_EN: when defined deltas accumulate with saturation;
// when undefined each packet overwrites the accumulator.
module mouse_delta_acc
  import msx_mouse_pkg::*;
(
  input  logic       clk,
  input  logic       srst,
  input  logic       add_en,
  input  logic [8:0] delta,
  input  logic       neg,
  input  logic       clr,
  output logic [7:0] acc
);

  logic [7:0]        acc_reg;
  logic [7:0]        acc_next;
  logic signed [9:0] delta_ext;
  logic signed [9:0] delta_signed;
  logic [7:0]        delta_sat;
  logic [7:0]        base;
`ifdef MSX_MOUSE_ACCUM_EN
  logic signed [9:0] sum;
`endif

  always_comb begin
    // Negating in 10 bits lets -256 become +256 before it saturates to +127.
    delta_ext    = {delta[8], delta};
    delta_signed = neg ? -delta_ext : delta_ext;
    delta_sat    = sat8(delta_signed);
    base         = clr ? 8'h00 : acc_reg;
`ifdef MSX_MOUSE_ACCUM_EN
    sum      = $signed({base[7], base[7], base}) +
               $signed({delta_sat[7], delta_sat[7], delta_sat});
    acc_next = add_en ? sat8(sum) : base;
`else
    acc_next = add_en ? delta_sat : base;
`endif
  end

  always_ff @(posedge clk) begin
    if (srst) acc_reg <= 8'h00;
    else      acc_reg <= acc_next;
  end

  assign acc = acc_reg;

endmodule

// File: rtl/msx_mouse_port.sv
// msx_mouse_port: MSX mouse protocol engine for joystick port A.
//   clk_sys      : system clock
//   reset        : synchronous active-high reset
//   mouse_strobe : one-cycle pulse, new PS/2 packet on mouse_x/mouse_y
//   mouse_x/y    : signed 9-bit deltas (X right positive, Y up positive)
//   mouse_btn    : {right, left}, active-high
//   joy_in       : joystick A, active-low
//   msx_str      : port strobe, each toggle requests the next nibble
//   port_out     : 6-bit value presented to the core's joystick A input
//   mouse_en     : mouse mode active
// Parameter TIMEOUT_CYCLES: strobe-idle cycles before returning to NIB0.
// Macro MSX_MOUSE_ACCUM_EN (in mouse_delta_acc): accumulate across packets.
module msx_mouse_port
  import msx_mouse_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       mouse_strobe,
  input  logic [8:0] mouse_x,
  input  logic [8:0] mouse_y,
  input  logic [1:0] mouse_btn,
  input  logic [5:0] joy_in,
  input  logic       msx_str,
  output logic [5:0] port_out,
  output logic       mouse_en
);

  localparam int            CW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LOAD = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TO_ONE  = CW'(1);
  localparam logic [CW-1:0] TO_ZERO = '0;

  nib_state_t    state_reg;
  logic          str_d_reg;
  logic          mouse_en_reg;
  logic [5:0]    port_out_reg;
  logic [3:0]    nib_reg;
  logic [CW-1:0] to_cnt_reg;
  logic [7:0]    snap_x_reg;
  logic [7:0]    snap_y_reg;
  logic [7:0]    acc_x;
  logic [7:0]    acc_y;

  logic          mouse_en_next;
  logic          str_edge;
  logic          nib0_edge;
  logic [3:0]    nib_sel;
  logic [3:0]    nib_next;
  nib_state_t    state_adv;

  mouse_delta_acc u_acc_x (
    .clk    (clk_sys),
    .srst   (reset),
    .add_en (mouse_strobe),
    .delta  (mouse_x),
    .neg    (1'b0),
    .clr    (nib0_edge),
    .acc    (acc_x)
  );

  // MSX counts up as negative Y, so the Y axis is negated on intake.
  mouse_delta_acc u_acc_y (
    .clk    (clk_sys),
    .srst   (reset),
    .add_en (mouse_strobe),
    .delta  (mouse_y),
    .neg    (1'b1),
    .clr    (nib0_edge),
    .acc    (acc_y)
  );

  always_comb begin
    mouse_en_next = mouse_en_reg;
    if (mouse_strobe)          mouse_en_next = 1'b1;
    else if (joy_in != 6'h3F)  mouse_en_next = 1'b0;

    str_edge  = mouse_en_reg && (msx_str != str_d_reg);
    nib0_edge = str_edge && (state_reg == NIB0);

    // NIB0 reads the live accumulator because the snapshot is taken on that edge.
    nib_sel   = nib_rev(acc_x, 1'b1);
    state_adv = NIB1;
    case (state_reg)
      NIB0: begin nib_sel = nib_rev(acc_x, 1'b1);      state_adv = NIB1; end
      NIB1: begin nib_sel = nib_rev(snap_x_reg, 1'b0); state_adv = NIB2; end
      NIB2: begin nib_sel = nib_rev(snap_y_reg, 1'b1); state_adv = NIB3; end
      NIB3: begin nib_sel = nib_rev(snap_y_reg, 1'b0); state_adv = NIB0; end
      default: begin nib_sel = 4'hF;                  state_adv = NIB0; end
    endcase
    nib_next = str_edge ? nib_sel : nib_reg;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_reg    <= NIB0;
      str_d_reg    <= msx_str;
      mouse_en_reg <= 1'b0;
      port_out_reg <= PORT_RESET;
      nib_reg      <= PORT_RESET[3:0];
      to_cnt_reg   <= TO_ZERO;
      snap_x_reg   <= 8'h00;
      snap_y_reg   <= 8'h00;
    end else begin
      str_d_reg    <= msx_str;
      mouse_en_reg <= mouse_en_next;
      nib_reg      <= nib_next;
      port_out_reg <= mouse_en_next ? {~mouse_btn, nib_next} : joy_in;

      if (str_edge)                to_cnt_reg <= TO_LOAD;
      else if (to_cnt_reg != TO_ZERO) to_cnt_reg <= to_cnt_reg - TO_ONE;

      // An edge takes priority over a timeout expiring in the same cycle.
      if (!mouse_en_reg)           state_reg <= NIB0;
      else if (str_edge)           state_reg <= state_adv;
      else if (to_cnt_reg == TO_ONE) state_reg <= NIB0;

      if (nib0_edge) begin
        snap_x_reg <= acc_x;
        snap_y_reg <= acc_y;
      end
    end
  end

  assign port_out = port_out_reg;
  assign mouse_en = mouse_en_reg;

endmodule
